// File: rtl/rob_ctrl_pkg.sv
// Shared machine-wide constants and reorder-buffer types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package common;
  localparam int MACHINE_WIDTH = 2;
  localparam int FU_NUM        = 4;
  typedef logic [31:0] word_t;
endpackage

package rob_pkg;
  import common::*;

  // Default geometry; rob_ctrl re-exposes these as overridable parameters.
  localparam int ROB_DEPTH_DEF = 16;
  localparam int PREG_W_DEF    = 6;
  localparam int AW_DEF        = $clog2(ROB_DEPTH_DEF);

  typedef logic [AW_DEF-1:0]     rob_addr_t;
  typedef logic [4:0]            areg_t;
  typedef logic [PREG_W_DEF-1:0] preg_t;

  // Full entry view at default geometry: status bits plus payload.
  typedef struct packed {
    logic  valid;
    logic  complete;
    areg_t dst;
    preg_t preg;
    word_t pc;
    word_t data;
  } rob_entry_t;

  // One retiring lane as seen by the commit stage.
  typedef struct packed {
    logic  valid;
    areg_t dst;
    preg_t preg;
    word_t data;
    word_t pc;
  } commit_t;
endpackage

// File: rtl/rob_commit_sel.sv
// Picks which of the oldest MACHINE_WIDTH entries retire this cycle.
// Latency: purely combinational from registered head-entry status.
// Backpressure: commit_ready_i low or flush_i high retires nothing.
module rob_commit_sel #(
  parameter int MACHINE_WIDTH = 2,
  parameter int AW            = 4
) (
  input  logic [MACHINE_WIDTH-1:0] head_done_i,
  input  logic [AW:0]              count_i,
  input  logic                     commit_ready_i,
  input  logic                     flush_i,
  output logic [MACHINE_WIDTH-1:0] commit_valid_o,
  output logic [AW:0]              commit_cnt_o
);

  logic [MACHINE_WIDTH:0] run;

  // Prefix-AND: the first not-done (or non-existent) entry stops all younger lanes.
  always_comb begin
    run            = '0;
    commit_valid_o = '0;
    commit_cnt_o   = '0;
    run[0]         = commit_ready_i & ~flush_i;
    for (int k = 0; k < MACHINE_WIDTH; k++) begin
      run[k+1]          = run[k] & head_done_i[k] & ((AW+1)'(k) < count_i);
      commit_valid_o[k] = run[k+1];
      if (run[k+1]) begin
        commit_cnt_o = commit_cnt_o + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder buffer: multi-lane allocate, multi-port writeback, in-order multi-lane commit.
// Latency: alloc -> writeback next cycle -> commit visible the cycle after (2 cycles).
// Backpressure: alloc_ready drops below MACHINE_WIDTH free slots; commit_ready stalls retire.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int MACHINE_WIDTH = common::MACHINE_WIDTH,
  parameter int ROB_DEPTH     = ROB_DEPTH_DEF,
  parameter int WB_PORTS      = common::FU_NUM,
  parameter int PREG_W        = PREG_W_DEF,
  localparam int AW           = $clog2(ROB_DEPTH)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [MACHINE_WIDTH-1:0]      alloc_valid,
  input  logic [MACHINE_WIDTH*5-1:0]    alloc_dst,
  input  logic [MACHINE_WIDTH*PREG_W-1:0] alloc_preg,
  input  logic [MACHINE_WIDTH*32-1:0]   alloc_pc,
  output logic                          alloc_ready,
  output logic [MACHINE_WIDTH*AW-1:0]   rob_addr,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*AW-1:0]        wb_addr,
  input  logic [WB_PORTS*32-1:0]        wb_data,
  input  logic                          commit_ready,
  output logic [MACHINE_WIDTH-1:0]      commit_valid,
  output logic [MACHINE_WIDTH*5-1:0]    commit_dst,
  output logic [MACHINE_WIDTH*PREG_W-1:0] commit_preg,
  output logic [MACHINE_WIDTH*32-1:0]   commit_data,
  output logic [MACHINE_WIDTH*32-1:0]   commit_pc,
  input  logic                          flush,
  output logic                          empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(ROB_DEPTH);
  localparam logic [AW:0] MW_C    = (AW+1)'(MACHINE_WIDTH);

  logic [AW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [AW:0]          count_q, count_d;
  logic [ROB_DEPTH-1:0] valid_q, valid_d, complete_q, complete_d;
  logic [AW:0]          alloc_cnt, commit_cnt;
  logic [MACHINE_WIDTH-1:0] head_done;
  logic                 alloc_fire;

  // Payload storage is never reset; valid_q gates every use of it.
  areg_t                dst_mem  [ROB_DEPTH];
  logic [PREG_W-1:0]    preg_mem [ROB_DEPTH];
  common::word_t        pc_mem   [ROB_DEPTH];
  common::word_t        data_mem [ROB_DEPTH];

  // Free-space test uses registered count only, so same-cycle commits do not help.
  assign alloc_ready = (DEPTH_C - count_q) >= MW_C;
  assign alloc_fire  = alloc_ready & ~flush;
  assign empty       = (count_q == '0);

  // Tags offered to rename and the head-window view used by commit.
  always_comb begin
    rob_addr    = '0;
    head_done   = '0;
    commit_dst  = '0;
    commit_preg = '0;
    commit_data = '0;
    commit_pc   = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      rob_addr[i*AW +: AW]        = tail_q + AW'(i);
      head_done[i]                = valid_q[head_q + AW'(i)] & complete_q[head_q + AW'(i)];
      commit_dst[i*5 +: 5]        = dst_mem[head_q + AW'(i)];
      commit_preg[i*PREG_W +: PREG_W] = preg_mem[head_q + AW'(i)];
      commit_data[i*32 +: 32]     = data_mem[head_q + AW'(i)];
      commit_pc[i*32 +: 32]       = pc_mem[head_q + AW'(i)];
    end
  end

  rob_commit_sel #(
    .MACHINE_WIDTH (MACHINE_WIDTH),
    .AW            (AW)
  ) u_commit_sel (
    .head_done_i    (head_done),
    .count_i        (count_q),
    .commit_ready_i (commit_ready),
    .flush_i        (flush),
    .commit_valid_o (commit_valid),
    .commit_cnt_o   (commit_cnt)
  );

  // Next-state status bits and pointers; writeback, then retire, then allocate.
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    alloc_cnt  = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && valid_q[wb_addr[p*AW +: AW]]) begin
        complete_d[wb_addr[p*AW +: AW]] = 1'b1;
      end
    end
    for (int k = 0; k < MACHINE_WIDTH; k++) begin
      if (commit_valid[k]) begin
        valid_d[head_q + AW'(k)] = 1'b0;
      end
    end
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      if (alloc_fire && alloc_valid[i]) begin
        valid_d[tail_q + AW'(i)]    = 1'b1;
        complete_d[tail_q + AW'(i)] = 1'b0;
        alloc_cnt                   = alloc_cnt + (AW+1)'(1);
      end
    end
    head_d  = AW'(head_q + commit_cnt);
    tail_d  = AW'(tail_q + alloc_cnt);
    count_d = count_q + alloc_cnt - commit_cnt;
    // Flush wins over everything that happened this cycle.
    if (flush) begin
      valid_d    = '0;
      complete_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      complete_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      complete_q <= complete_d;
    end
  end

  // Payload writes: allocation fields and writeback results, dropped on flush.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && valid_q[wb_addr[p*AW +: AW]]) begin
          data_mem[wb_addr[p*AW +: AW]] <= wb_data[p*32 +: 32];
        end
      end
    end
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      if (alloc_fire && alloc_valid[i]) begin
        dst_mem[tail_q + AW'(i)]  <= alloc_dst[i*5 +: 5];
        preg_mem[tail_q + AW'(i)] <= alloc_preg[i*PREG_W +: PREG_W];
        pc_mem[tail_q + AW'(i)]   <= alloc_pc[i*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl against a queue-based in-order model.
// Latency: model mirrors retire-next-edge, writeback-visible-next-cycle behaviour.
// Backpressure: exercises alloc_ready full/refill and commit_ready stalls.
module tb_rob_ctrl;
  localparam int MW = 2;
  localparam int D  = 16;
  localparam int WB = 4;
  localparam int PW = 6;
  localparam int AW = 4;

  logic            clk, resetn;
  logic [MW-1:0]   alloc_valid;
  logic [MW*5-1:0] alloc_dst;
  logic [MW*PW-1:0] alloc_preg;
  logic [MW*32-1:0] alloc_pc;
  logic            alloc_ready;
  logic [MW*AW-1:0] rob_addr;
  logic [WB-1:0]   wb_valid;
  logic [WB*AW-1:0] wb_addr;
  logic [WB*32-1:0] wb_data;
  logic            commit_ready;
  logic [MW-1:0]   commit_valid;
  logic [MW*5-1:0] commit_dst;
  logic [MW*PW-1:0] commit_preg;
  logic [MW*32-1:0] commit_data;
  logic [MW*32-1:0] commit_pc;
  logic            flush, empty;

  int total = 0;
  int bad   = 0;

  rob_ctrl #(.MACHINE_WIDTH(MW), .ROB_DEPTH(D), .WB_PORTS(WB), .PREG_W(PW)) dut (
    .clk(clk), .resetn(resetn),
    .alloc_valid(alloc_valid), .alloc_dst(alloc_dst), .alloc_preg(alloc_preg),
    .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .rob_addr(rob_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_dst(commit_dst),
    .commit_preg(commit_preg), .commit_data(commit_data), .commit_pc(commit_pc),
    .flush(flush), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program-order queue of live instructions.
  typedef struct {
    int          tag;
    logic [4:0]  dst;
    logic [5:0]  preg;
    logic [31:0] pc;
    logic [31:0] data;
    bit          done;
  } ment_t;
  ment_t mq[$];
  int    m_tail = 0;

  function automatic int m_ncommit();
    int  n = 0;
    bit  go = (commit_ready === 1'b1) && (flush !== 1'b1);
    for (int k = 0; k < MW; k++) begin
      if (go && k < mq.size() && mq[k].done) n++;
      else go = 1'b0;
    end
    return n;
  endfunction

  function automatic bit m_alloc_ok();
    return (D - mq.size()) >= MW;
  endfunction

  // Two writeback ports naming one entry is illegal stimulus.
  always @(posedge clk) begin
    for (int p = 0; p < WB; p++)
      for (int q = p + 1; q < WB; q++)
        if (wb_valid[p] && wb_valid[q] && wb_addr[p*AW +: AW] == wb_addr[q*AW +: AW]) begin
          bad++;
          $display("FAIL wb_dup ports %0d/%0d same entry %0d", p, q, wb_addr[p*AW +: AW]);
        end
  end

  task automatic tick();
    int  n;
    bit  ok;
    @(posedge clk);
    n  = m_ncommit();
    ok = m_alloc_ok();
    if (flush) begin
      mq.delete();
      m_tail = 0;
    end else begin
      for (int p = 0; p < WB; p++)
        if (wb_valid[p])
          for (int j = 0; j < mq.size(); j++)
            if (mq[j].tag == int'(wb_addr[p*AW +: AW])) begin
              mq[j].done = 1'b1;
              mq[j].data = wb_data[p*32 +: 32];
            end
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      if (ok)
        for (int i = 0; i < MW; i++)
          if (alloc_valid[i]) begin
            mq.push_back('{m_tail, alloc_dst[i*5 +: 5], alloc_preg[i*PW +: PW],
                           alloc_pc[i*32 +: 32], 32'h0, 1'b0});
            m_tail = (m_tail + 1) % D;
          end
    end
    #1;
  endtask

  task automatic clear_in();
    alloc_valid = '0;
    wb_valid    = '0;
    flush       = 1'b0;
  endtask

  task automatic set_alloc(input int i, input logic [4:0] d, input logic [5:0] p, input logic [31:0] pc);
    alloc_valid[i]        = 1'b1;
    alloc_dst[i*5 +: 5]   = d;
    alloc_preg[i*PW +: PW] = p;
    alloc_pc[i*32 +: 32]  = pc;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] d);
    wb_valid[p]           = 1'b1;
    wb_addr[p*AW +: AW]   = AW'(tag);
    wb_data[p*32 +: 32]   = d;
  endtask

  task automatic test_reset();
    resetn = 1'b0; commit_ready = 1'b1;
    alloc_dst = '0; alloc_preg = '0; alloc_pc = '0; wb_addr = '0; wb_data = '0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%b exp=1", alloc_ready); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (rob_addr !== 8'h10) begin bad++; $display("FAIL reset_rob_addr got=%h exp=10", rob_addr); end
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL reset_commit_valid got=%b exp=00", commit_valid); end
    resetn = 1'b1;
    mq.delete(); m_tail = 0;
  endtask

  task automatic test_alloc_basic();
    set_alloc(0, 5'd3, 6'd10, 32'h100);
    set_alloc(1, 5'd4, 6'd11, 32'h104);
    #1;
    total++; if (rob_addr !== 8'h10) begin bad++; $display("FAIL alloc_tags got=%h exp=10", rob_addr); end
    tick();
    clear_in();
    #1;
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL alloc_empty got=%b exp=0", empty); end
    total++; if (rob_addr !== 8'h32) begin bad++; $display("FAIL alloc_next_tags got=%h exp=32", rob_addr); end
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL alloc_nocommit got=%b exp=00", commit_valid); end
  endtask

  task automatic test_wb_commit();
    set_wb(0, 1, 32'h1111_2222);
    tick(); clear_in(); #1;
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL wb_young_only got=%b exp=00", commit_valid); end
    set_wb(1, 0, 32'hDEAD_BEEF); #1;
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL wb_same_cycle got=%b exp=00", commit_valid); end
    tick(); clear_in(); #1;
    total++; if (commit_valid !== 2'b11) begin bad++; $display("FAIL wb_commit_pair got=%b exp=11", commit_valid); end
    total++; if (commit_data !== {32'h1111_2222, 32'hDEAD_BEEF}) begin bad++; $display("FAIL wb_commit_data got=%h exp=1111_2222_deadbeef", commit_data); end
    total++; if (commit_dst !== {5'd4, 5'd3}) begin bad++; $display("FAIL wb_commit_dst got=%h exp=083", commit_dst); end
    tick(); #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wb_drained got=%b exp=1", empty); end
    // Head must now be 2: a single new entry at tag 2 retires on lane 0.
    set_alloc(0, 5'd7, 6'd20, 32'h200);
    tick(); clear_in();
    set_wb(0, 2, 32'h0000_0777);
    tick(); clear_in(); #1;
    total++; if (commit_valid !== 2'b01) begin bad++; $display("FAIL head2_commit got=%b exp=01", commit_valid); end
    total++; if (commit_dst[4:0] !== 5'd7) begin bad++; $display("FAIL head2_dst got=%0d exp=7", commit_dst[4:0]); end
    tick();
  endtask

  task automatic test_flush();
    set_alloc(0, 5'd1, 6'd1, 32'h300); set_alloc(1, 5'd2, 6'd2, 32'h304);
    tick();
    set_alloc(0, 5'd5, 6'd5, 32'h308); set_alloc(1, 5'd6, 6'd6, 32'h30C);
    tick(); clear_in();
    set_wb(0, 3, 32'hA); set_wb(1, 4, 32'hB);
    tick(); clear_in();
    flush = 1'b1; alloc_valid = 2'b11; set_wb(2, 5, 32'hC); #1;
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL flush_forces_nocommit got=%b exp=00", commit_valid); end
    tick(); clear_in(); #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b exp=1", empty); end
    total++; if (rob_addr !== 8'h10) begin bad++; $display("FAIL flush_tags got=%h exp=10", rob_addr); end
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL flush_after_commit got=%b exp=00", commit_valid); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL flush_alloc_ready got=%b exp=1", alloc_ready); end
  endtask

  task automatic test_fill();
    commit_ready = 1'b0;
    for (int pr = 0; pr < 8; pr++) begin
      set_alloc(0, 5'($urandom), 6'($urandom), $urandom);
      set_alloc(1, 5'($urandom), 6'($urandom), $urandom);
      tick(); clear_in();
      if (pr == 6) begin
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL fill_7pairs got=%b exp=1", alloc_ready); end
      end
      if (pr == 7) begin
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b exp=0", alloc_ready); end
        total++; if (rob_addr !== 8'h10) begin bad++; $display("FAIL fill_tail_wrap got=%h exp=10", rob_addr); end
      end
    end
    alloc_valid = 2'b11;
    tick(); clear_in();
    total++; if (rob_addr !== 8'h10) begin bad++; $display("FAIL full_alloc_ignored got=%h exp=10", rob_addr); end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_still_full got=%b exp=0", alloc_ready); end
  endtask

  task automatic test_stall_wrap();
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < WB; p++) set_wb(p, 4*c + p, $urandom);
      tick(); clear_in();
    end
    for (int c = 0; c < 3; c++) begin
      total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL stall_cycle%0d got=%b exp=00", c, commit_valid); end
      tick();
    end
    commit_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      int          n, np;
      logic [1:0]  ecv;
      set_alloc(0, 5'($urandom), 6'($urandom), $urandom);
      set_alloc(1, 5'($urandom), 6'($urandom), $urandom);
      np = 0;
      for (int j = 0; j < mq.size(); j++)
        if (!mq[j].done && np < WB) begin set_wb(np, mq[j].tag, $urandom); np++; end
      #1;
      n = m_ncommit();
      ecv = '0;
      for (int k = 0; k < n; k++) ecv[k] = 1'b1;
      total++; if (commit_valid !== ecv) begin bad++; $display("FAIL drain_cv c=%0d got=%b exp=%b", c, commit_valid, ecv); end
      total++; if (alloc_ready !== m_alloc_ok()) begin bad++; $display("FAIL drain_ready c=%0d got=%b exp=%b", c, alloc_ready, m_alloc_ok()); end
      for (int k = 0; k < n; k++) begin
        total++; if (commit_pc[k*32 +: 32] !== mq[k].pc || commit_data[k*32 +: 32] !== mq[k].data) begin
          bad++; $display("FAIL drain_lane c=%0d k=%0d got=%h/%h exp=%h/%h", c, k,
                          commit_pc[k*32 +: 32], commit_data[k*32 +: 32], mq[k].pc, mq[k].data);
        end
      end
      tick(); clear_in();
    end
  endtask

  task automatic test_async_reset();
    flush = 1'b1; tick(); clear_in();
    commit_ready = 1'b1;
    alloc_valid = 2'b11; tick();
    alloc_valid = 2'b11; tick();
    alloc_valid = 2'b01; tick(); clear_in();
    total++; if (rob_addr !== 8'h65) begin bad++; $display("FAIL five_entries_tail got=%h exp=65", rob_addr); end
    @(negedge clk); #2;
    resetn = 1'b0; #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL async_empty got=%b exp=1", empty); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL async_alloc_ready got=%b exp=1", alloc_ready); end
    total++; if (rob_addr !== 8'h10) begin bad++; $display("FAIL async_tags got=%h exp=10", rob_addr); end
    mq.delete(); m_tail = 0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      int          n, r;
      int          used[$];
      logic [1:0]  ecv;
      logic [7:0]  era;
      r = $urandom_range(0, 2);
      alloc_valid = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      alloc_dst = MW*5'($urandom); alloc_preg = 12'($urandom); alloc_pc = {$urandom, $urandom};
      commit_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 99) == 0);
      wb_valid = '0;
      for (int p = 0; p < WB; p++) begin
        int tag;
        if ($urandom_range(0, 1) == 1) begin
          if (mq.size() > 0 && $urandom_range(0, 7) != 0) tag = mq[$urandom_range(0, mq.size() - 1)].tag;
          else tag = $urandom_range(0, D - 1);
          if (!(tag inside {used})) begin used.push_back(tag); set_wb(p, tag, $urandom); end
        end
      end
      #1;
      n = m_ncommit();
      ecv = '0;
      for (int k = 0; k < n; k++) ecv[k] = 1'b1;
      for (int i = 0; i < MW; i++) era[i*AW +: AW] = AW'((m_tail + i) % D);
      total++; if (commit_valid !== ecv) begin bad++; $display("FAIL rnd_cv c=%0d got=%b exp=%b", c, commit_valid, ecv); end
      total++; if (alloc_ready !== m_alloc_ok()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, alloc_ready, m_alloc_ok()); end
      total++; if (empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty c=%0d got=%b exp=%b", c, empty, mq.size() == 0); end
      total++; if (rob_addr !== era) begin bad++; $display("FAIL rnd_tags c=%0d got=%h exp=%h", c, rob_addr, era); end
      for (int k = 0; k < n; k++) begin
        total++;
        if (commit_dst[k*5 +: 5] !== mq[k].dst || commit_preg[k*PW +: PW] !== mq[k].preg ||
            commit_pc[k*32 +: 32] !== mq[k].pc || commit_data[k*32 +: 32] !== mq[k].data) begin
          bad++;
          $display("FAIL rnd_lane c=%0d k=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", c, k,
                   commit_dst[k*5 +: 5], commit_preg[k*PW +: PW], commit_pc[k*32 +: 32], commit_data[k*32 +: 32],
                   mq[k].dst, mq[k].preg, mq[k].pc, mq[k].data);
        end
      end
      tick(); clear_in();
    end
  endtask

  initial begin
    test_reset();
    test_alloc_basic();
    test_wb_commit();
    test_flush();
    test_fill();
    test_stall_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
